// File: rtl/ori_pkg.sv
// Shared definitions for the Orion-128 raster scan path: default raster
// geometry, counter widths and the screen-page address encoding.
package ori_pkg;

  localparam int HC_W   = 6;
  localparam int VC_W   = 9;
  localparam int PAGE_W = 2;

  localparam int DEF_H_TOTAL  = 64;
  localparam int DEF_H_ACTIVE = 48;
  localparam int DEF_HS_START = 52;
  localparam int DEF_HS_LEN   = 4;
  localparam int DEF_V_TOTAL  = 312;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_VS_START = 276;
  localparam int DEF_VS_LEN   = 4;

  // The page select is inverted into the top address bits: page 0 sits at
  // 0xC000 and page 3 at 0x0000.
  function automatic logic [15:0] page_base(input logic [PAGE_W-1:0] page);
    return {~page, 14'h0000};
  endfunction

endpackage

// File: rtl/ori_pix_shift.sv
// Video byte shifter: loads a RAM byte (or blank) and serializes it MSB first,
// one dot per pixel enable, with a registered pixel output.
module ori_pix_shift (
  input  logic       clk,
  input  logic       por,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] data,
  input  logic       active,
  output logic       pix
);

  logic [7:0] sh;
  logic [7:0] sh_next;
  logic       pblank;
  logic       pblank_next;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    sh_next     = sh;
    pblank_next = pblank;
    if (load) begin
      sh_next     = active ? data : 8'h00;
      pblank_next = ~active;
    end else if (shift) begin
      sh_next = {sh[6:0], 1'b0};
    end
  end

  // The pixel is registered from the next-state values so bit 7 appears one
  // cycle after the load rather than two.
  always_ff @(posedge clk or posedge por) begin
    if (por) begin
      sh     <= 8'h00;
      pblank <= 1'b1;
      pix    <= 1'b0;
    end else if (rst) begin
      sh     <= 8'h00;
      pblank <= 1'b1;
      pix    <= 1'b0;
    end else begin
      sh     <= sh_next;
      pblank <= pblank_next;
      pix    <= sh_next[7] & ~pblank_next;
    end
  end

endmodule

// File: rtl/ori_video_scan.sv
// Orion-128 raster scan generator: byte-slot/line counters, column-major video
// address, sync/blank decode and the serial pixel stream.
module ori_video_scan
  import ori_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_LEN   = DEF_VS_LEN
) (
  input  logic              clk_i,
  input  logic              por_i,
  input  logic              rst_i,
  input  logic              hor_inc_i,
  input  logic              cke_dot_i,
  input  logic              vid_ld_i,
  input  logic [7:0]        vid_data_i,
  input  logic [PAGE_W-1:0] vid_page_i,
  output logic [15:0]       vid_addr_o,
  output logic              hsync_n_o,
  output logic              vsync_n_o,
  output logic              blank_o,
  output logic              pix_o,
  output logic              frame_o
);

  logic [HC_W-1:0]   hcnt;
  logic [VC_W-1:0]   vcnt;
  logic [PAGE_W-1:0] page;
  logic              h_wrap;
  logic              v_wrap;
  logic              active;
  logic              hs_on;
  logic              vs_on;

  assign h_wrap = int'(hcnt) == H_TOTAL - 1;
  assign v_wrap = int'(vcnt) == V_TOTAL - 1;
  assign active = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
  assign hs_on  = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_START + HS_LEN);
  assign vs_on  = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_START + VS_LEN);

  // Scan position and page; the page is resampled on every slot advance.
  always_ff @(posedge clk_i or posedge por_i) begin
    if (por_i) begin
      hcnt    <= '0;
      vcnt    <= '0;
      page    <= '0;
      frame_o <= 1'b0;
    end else if (rst_i) begin
      hcnt    <= '0;
      vcnt    <= '0;
      page    <= '0;
      frame_o <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      if (hor_inc_i) begin
        page <= vid_page_i;
        if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt    <= '0;
            frame_o <= 1'b1;
          end else begin
            vcnt <= vcnt + 1'b1;
          end
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Address and timing outputs follow the counters by one cycle.
  always_ff @(posedge clk_i or posedge por_i) begin
    if (por_i) begin
      vid_addr_o <= page_base('0);
      hsync_n_o  <= 1'b1;
      vsync_n_o  <= 1'b1;
      blank_o    <= 1'b0;
    end else if (rst_i) begin
      vid_addr_o <= page_base('0);
      hsync_n_o  <= 1'b1;
      vsync_n_o  <= 1'b1;
      blank_o    <= 1'b0;
    end else begin
      vid_addr_o <= page_base(page) | {2'b00, hcnt, vcnt[7:0]};
      hsync_n_o  <= ~hs_on;
      vsync_n_o  <= ~vs_on;
      blank_o    <= ~active;
    end
  end

  ori_pix_shift u_pix_shift (
    .clk    (clk_i),
    .por    (por_i),
    .rst    (rst_i),
    .load   (vid_ld_i),
    .shift  (cke_dot_i),
    .data   (vid_data_i),
    .active (active),
    .pix    (pix_o)
  );

endmodule
